ttfir_mac: RTL and testbench

- Parametrised successor to the single-tap TinyTapeout FIR.
- Implements an N_TAPS FIR filter with serially loadable signed coefficients and sign-magnitude sample input.
- Uses a time-multiplexed single multiplier-accumulator, a valid/busy handshake, and a rounded, saturated output.
- Sits directly behind the 8-bit io_in/io_out pin mapping of the top-level wrapper.

---
 rtl/ttfir_mac_if.sv | 28 ++
 rtl/ttfir_mac.sv | 131 +++++++++++++
 tb/tb_ttfir_mac.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ttfir_mac_if.sv
// Sample/coefficient/result bundle between the pin wrapper and the FIR MAC core.
// Handshake: x_valid is sampled only while busy=0, with no queuing. coef_load takes
// priority over x_valid. y_valid is a one-cycle strobe, and y_out/sat hold between strobes.
interface ttfir_mac_if #(
    parameter int BW_IN   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_OUT  = 8
);
    logic [BW_IN-2:0]   x_in;
    logic               x_in_sign;
    logic               x_valid;
    logic [BW_COEF-1:0] coef_in;
    logic               coef_load;
    logic               busy;
    logic [BW_OUT-1:0]  y_out;
    logic               y_valid;
    logic               sat;

    modport master (
        output x_in, x_in_sign, x_valid, coef_in, coef_load,
        input  busy, y_out, y_valid, sat
    );

    modport slave (
        input  x_in, x_in_sign, x_valid, coef_in, coef_load,
        output busy, y_out, y_valid, sat
    );
endinterface

// File: rtl/ttfir_mac.sv
// N-tap FIR filter built around one time-multiplexed multiplier-accumulator.
// Coefficients shift in serially, samples arrive in sign-magnitude form, and the output is rounded and saturated.
module ttfir_mac #(
    parameter int N_TAPS  = 4,
    parameter int BW_IN   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_OUT  = 8,
    parameter int SHIFT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    ttfir_mac_if.slave  bus,
    output logic [1:0]  state_o
);
    localparam int ACC_W  = BW_IN + BW_COEF + $clog2(N_TAPS);
    localparam int PROD_W = BW_IN + BW_COEF;
    localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int RW     = ACC_W + 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_TAPS - 1);
    localparam logic signed [RW-1:0] RND      = RW'((2 ** SHIFT) / 2);
    localparam logic signed [RW-1:0] Y_MAX    = RW'((2 ** (BW_OUT - 1)) - 1);
    localparam logic signed [RW-1:0] Y_MIN    = RW'(-(2 ** (BW_OUT - 1)));
    localparam logic [BW_COEF-1:0]   C0_RST   = BW_COEF'(2 ** SHIFT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [BW_COEF-1:0] c_q [N_TAPS];
    logic signed [BW_IN-1:0]   d_q [N_TAPS];
    logic signed [ACC_W-1:0]   acc_q;
    logic [IDX_W-1:0]          idx_q;
    logic [BW_OUT-1:0]         y_q;
    logic                      y_valid_q;
    logic                      sat_q;

    logic                      shift_coef;
    logic                      accept;
    logic signed [BW_IN-1:0]   x_mag;
    logic signed [BW_IN-1:0]   x_conv;
    logic signed [PROD_W-1:0]  prod;
    logic signed [RW-1:0]      rnd_sum;
    logic signed [RW-1:0]      r;
    logic [BW_OUT-1:0]         y_d;
    logic                      sat_d;

    // A coefficient shift wins over a simultaneous sample, which is then dropped.
    assign shift_coef = (state_q == IDLE) && bus.coef_load;
    assign accept     = (state_q == IDLE) && !bus.coef_load && bus.x_valid;

    assign x_mag  = {1'b0, bus.x_in};
    assign x_conv = bus.x_in_sign ? -x_mag : x_mag;
    assign prod   = PROD_W'(c_q[idx_q]) * PROD_W'(d_q[idx_q]);

    // Round half up, then floor through the arithmetic shift.
    assign rnd_sum = RW'(acc_q) + RND;
    assign r       = rnd_sum >>> SHIFT;

    always_comb begin
        y_d   = r[BW_OUT-1:0];
        sat_d = 1'b0;
        if (r > Y_MAX) begin
            y_d   = Y_MAX[BW_OUT-1:0];
            sat_d = 1'b1;
        end else if (r < Y_MIN) begin
            y_d   = Y_MIN[BW_OUT-1:0];
            sat_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (idx_q == LAST_IDX) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                c_q[i] <= (i == 0) ? C0_RST : '0;
                d_q[i] <= '0;
            end
            acc_q     <= '0;
            idx_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            if (shift_coef) begin
                c_q[0] <= bus.coef_in;
                for (int i = 1; i < N_TAPS; i++) c_q[i] <= c_q[i-1];
            end
            if (accept) begin
                d_q[0] <= x_conv;
                for (int i = 1; i < N_TAPS; i++) d_q[i] <= d_q[i-1];
                acc_q <= '0;
                idx_q <= '0;
            end
            if (state_q == MAC) begin
                acc_q <= acc_q + ACC_W'(prod);
                idx_q <= idx_q + IDX_W'(1);
            end
            y_valid_q <= (state_q == OUT);
            if (state_q == OUT) begin
                y_q   <= y_d;
                sat_q <= sat_d;
            end
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.y_out   = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.sat     = sat_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_ttfir_mac.sv
// Bench for ttfir_mac: hand-derived vector table, multi-cycle corner sequences,
// and random traffic checked against an arithmetic FIR model.
module tb_ttfir_mac;
    localparam int N_TAPS  = 4;
    localparam int BW_IN   = 6;
    localparam int BW_COEF = 6;
    localparam int BW_OUT  = 8;
    localparam int SHIFT   = 2;
    localparam int EW      = BW_OUT + 1;
    localparam int YMAX    = (2 ** (BW_OUT - 1)) - 1;
    localparam int YMIN    = -(2 ** (BW_OUT - 1));

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    ttfir_mac_if #(.BW_IN(BW_IN), .BW_COEF(BW_COEF), .BW_OUT(BW_OUT)) bus ();

    ttfir_mac #(
        .N_TAPS(N_TAPS), .BW_IN(BW_IN), .BW_COEF(BW_COEF), .BW_OUT(BW_OUT), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];

    // Model state: coefficients and delay line as plain integers.
    int m_c[N_TAPS];
    int m_d[N_TAPS];

    typedef struct {
        int op;       // 0 = sample, 1 = coefficient load
        int sign;
        int val;
        int exp_y;
        int exp_sat;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_TAPS; i++) begin
            m_c[i] = 0;
            m_d[i] = 0;
        end
        m_c[0] = 2 ** SHIFT;
    endfunction

    function automatic void model_coef(input int v);
        for (int i = N_TAPS - 1; i > 0; i--) m_c[i] = m_c[i-1];
        m_c[0] = (v >= 2 ** (BW_COEF - 1)) ? v - 2 ** BW_COEF : v;
    endfunction

    function automatic logic [EW-1:0] model_sample(input bit sign, input int mag);
        int acc;
        int r;
        bit s;
        logic [BW_OUT-1:0] yv;
        for (int i = N_TAPS - 1; i > 0; i--) m_d[i] = m_d[i-1];
        m_d[0] = sign ? -mag : mag;
        acc = 0;
        for (int i = 0; i < N_TAPS; i++) acc += m_c[i] * m_d[i];
        r = (acc + (2 ** SHIFT) / 2) >>> SHIFT;
        s = 1'b0;
        if (r > YMAX) begin
            r = YMAX;
            s = 1'b1;
        end else if (r < YMIN) begin
            r = YMIN;
            s = 1'b1;
        end
        yv = r[BW_OUT-1:0];
        return {s, yv};
    endfunction

    task automatic do_coef(input int v);
        bus.coef_in   = BW_COEF'(v);
        bus.coef_load = 1'b1;
        @(negedge clk);
        bus.coef_load = 1'b0;
        model_coef(v);
    endtask

    task automatic do_sample(input bit sign, input int mag, input string tag,
                             input bit use_tbl, input int tbl_y, input int tbl_sat);
        logic [EW-1:0] exp_v;
        int n;
        int exp_y;
        int exp_sat;
        bus.x_in      = (BW_IN - 1)'(mag);
        bus.x_in_sign = sign;
        bus.x_valid   = 1'b1;
        exp_q.push_back(model_sample(sign, mag));
        @(negedge clk);
        bus.x_valid = 1'b0;
        n = 0;
        while (!bus.y_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        exp_v   = exp_q.pop_front();
        exp_y   = use_tbl ? tbl_y : int'($signed(exp_v[BW_OUT-1:0]));
        exp_sat = use_tbl ? tbl_sat : int'(exp_v[BW_OUT]);
        check({tag, "_latency"}, n, N_TAPS + 1);
        check({tag, "_y"}, int'($signed(bus.y_out)), exp_y);
        check({tag, "_sat"}, int'(bus.sat), exp_sat);
        @(negedge clk);
        check({tag, "_one_cycle"}, int'(bus.y_valid), 0);
        check({tag, "_hold"}, int'($signed(bus.y_out)), exp_y);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        int cnt;
        int pulses;
        int last;
        int bad_gap;
        int bad_y;
        int n;

        bus.x_in      = '0;
        bus.x_in_sign = 1'b0;
        bus.x_valid   = 1'b0;
        bus.coef_in   = '0;
        bus.coef_load = 1'b0;
        rst = 1'b1;
        model_reset();

        // Asynchronous reset, observed before the first rising edge.
        #2 rst = 1'b0;
        #2;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_y", int'(bus.y_out), 0);
        check("reset_y_valid", int'(bus.y_valid), 0);
        check("reset_sat", int'(bus.sat), 0);
        check("reset_state", int'(state_dbg), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Hand-derived vectors with reset coefficients, impulse, saturation and restore.
        tbl.push_back('{0, 0, 13, 13, 0});
        tbl.push_back('{0, 1, 13, -13, 0});
        tbl.push_back('{0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 31, 31, 0});
        tbl.push_back('{0, 1, 31, -31, 0});
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 4, 0, 0});
        tbl.push_back('{1, 0, 3, 0, 0});
        tbl.push_back('{1, 0, 2, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0});
        tbl.push_back('{0, 0, 8, 2, 0});
        tbl.push_back('{0, 0, 0, 4, 0});
        tbl.push_back('{0, 0, 0, 6, 0});
        tbl.push_back('{0, 0, 0, 8, 0});
        for (int i = 0; i < 4; i++) tbl.push_back('{1, 0, 31, 0, 0});
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 31, 127, 1});
        tbl.push_back('{0, 1, 31, 127, 1});
        tbl.push_back('{0, 1, 31, 0, 0});
        tbl.push_back('{0, 1, 31, -128, 1});
        tbl.push_back('{0, 1, 31, -128, 1});
        tbl.push_back('{1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 4, 0, 0});
        tbl.push_back('{0, 0, 1, 1, 0});
        tbl.push_back('{0, 1, 1, -1, 0});

        foreach (tbl[i]) begin
            if (tbl[i].op == 1) do_coef(tbl[i].val);
            else do_sample(tbl[i].sign[0], tbl[i].val, $sformatf("vec%0d", i),
                           1'b1, tbl[i].exp_y, tbl[i].exp_sat);
        end

        // coef_load together with x_valid: coefficient shifts, sample is dropped.
        bus.x_in      = 5'd20;
        bus.x_in_sign = 1'b0;
        bus.x_valid   = 1'b1;
        bus.coef_in   = '0;
        bus.coef_load = 1'b1;
        @(negedge clk);
        bus.x_valid   = 1'b0;
        bus.coef_load = 1'b0;
        model_coef(0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.busy || bus.y_valid) cnt++;
            @(negedge clk);
        end
        check("collision_sample_dropped", cnt, 0);
        do_sample(1'b0, 12, "after_collision", 1'b0, 0, 0);

        // Random coefficient loads and samples against the model.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) do_coef(int'($urandom_range(0, 63)));
            else do_sample(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                           $sformatf("rand%0d", k), 1'b0, 0, 0);
        end

        // Back to pass-through, then hold x_valid high for 60 cycles.
        do_coef(0);
        do_coef(0);
        do_coef(0);
        do_coef(4);
        bus.x_in      = 5'd7;
        bus.x_in_sign = 1'b0;
        bus.x_valid   = 1'b1;
        pulses  = 0;
        last    = -1;
        bad_gap = 0;
        bad_y   = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (bus.y_valid) begin
                pulses++;
                if (last < 0 && cyc != N_TAPS + 2) bad_gap++;
                if (last >= 0 && cyc - last != N_TAPS + 2) bad_gap++;
                if (int'($signed(bus.y_out)) != 7) bad_y++;
                last = cyc;
            end
        end
        bus.x_valid = 1'b0;
        for (int k = 0; k < 10; k++) void'(model_sample(1'b0, 7));
        check("stream_pulse_count", pulses, 10);
        check("stream_pulse_spacing_errors", bad_gap, 0);
        check("stream_value_errors", bad_y, 0);
        @(negedge clk);

        // coef_load pulsed while busy must be ignored.
        bus.x_in    = 5'd9;
        bus.x_valid = 1'b1;
        @(negedge clk);
        bus.x_valid = 1'b0;
        check("busy_when_poked", int'(bus.busy), 1);
        bus.coef_in   = 6'd31;
        bus.coef_load = 1'b1;
        @(negedge clk);
        bus.coef_load = 1'b0;
        n = 0;
        while (!bus.y_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        void'(model_sample(1'b0, 9));
        check("poke_valid_seen", int'(bus.y_valid), 1);
        check("poke_y", int'($signed(bus.y_out)), 9);
        @(negedge clk);
        do_sample(1'b0, 11, "after_poke", 1'b1, 11, 0);

        // Asynchronous reset two cycles into the MAC phase.
        bus.x_in    = 5'd20;
        bus.x_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.x_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_y", int'(bus.y_out), 0);
        check("abort_y_valid", int'(bus.y_valid), 0);
        check("abort_sat", int'(bus.sat), 0);
        check("abort_state", int'(state_dbg), 0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.y_valid) cnt++;
        end
        check("abort_no_output", cnt, 0);
        model_reset();
        do_sample(1'b0, 5, "post_reset_passthrough", 1'b1, 5, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
